// File: rtl/operand_fetch_pkg.sv
// Shared core definitions for the register-read / ID-EX stage.
package operand_fetch_pkg;

  localparam int DATA_W   = 64;
  localparam int NREG     = 32;
  localparam int ZERO_REG = 31;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic [4:0] rd;
  } ex_ctrl_t;

endpackage

// File: rtl/operand_fetch_wb_select_decode.sv
// One-hot register-array write select with enable; the top register is
// hard-wired zero and never selected.
module wb_select_decode #(
  parameter int NREG = 32
) (
  input  logic            en,
  input  logic [4:0]      idx,
  output logic [NREG-1:0] sel
);

  always_comb begin
    sel = '0;
    if (en && (idx != 5'(NREG - 1)))
      sel[idx] = 1'b1;
  end

endmodule

// File: rtl/operand_fetch.sv
// Register read with writeback bypass, load-use hazard detection and the
// ID/EX pipeline register.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int NREG   = operand_fetch_pkg::NREG
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NREG*DATA_W-1:0] RegBus,
  input  logic                   IdValid,
  input  logic [4:0]             IdRn,
  input  logic [4:0]             IdRm,
  input  logic [4:0]             IdRd,
  input  logic                   IdRegWrite,
  input  logic                   IdMemRead,
  input  logic                   WbRegWrite,
  input  logic [4:0]             WbRd,
  input  logic [DATA_W-1:0]      WbData,
  input  logic                   Stall,
  input  logic                   Flush,
  output logic [NREG-1:0]        WbSelect,
  output logic                   HazardStall,
  output logic                   ExValid,
  output logic                   ExRegWrite,
  output logic                   ExMemRead,
  output logic [DATA_W-1:0]      ExA,
  output logic [DATA_W-1:0]      ExB,
  output logic [4:0]             ExRd
);

  localparam logic [4:0] ZR = 5'(NREG - 1);

  logic [DATA_W-1:0] op_a_p0;
  logic [DATA_W-1:0] op_b_p0;
  ex_ctrl_t          ctrl_p0;
  ex_ctrl_t          ctrl_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic              vld_p1;

  function automatic logic [DATA_W-1:0] read_port(
    input logic [NREG*DATA_W-1:0] bus,
    input logic [4:0]             src,
    input logic                   wb_en,
    input logic [4:0]             wb_rd,
    input logic [DATA_W-1:0]      wb_data
  );
    if (src == ZR)
      return '0;
    else if (wb_en && (wb_rd == src))
      return wb_data;
    else
      return bus[int'(src)*DATA_W +: DATA_W];
  endfunction

  wb_select_decode #(.NREG(NREG)) u_wb_select (
    .en  (WbRegWrite),
    .idx (WbRd),
    .sel (WbSelect)
  );

  // ---- stage p0: operand read, bypass, hazard detect ----
  always_comb begin
    op_a_p0 = read_port(RegBus, IdRn, WbRegWrite, WbRd, WbData);
    op_b_p0 = read_port(RegBus, IdRm, WbRegWrite, WbRd, WbData);

    ctrl_p0.valid     = IdValid;
    ctrl_p0.reg_write = IdRegWrite && IdValid;
    ctrl_p0.mem_read  = IdMemRead && IdValid;
    ctrl_p0.rd        = IdRd;
  end

  // Looks only at the registered EX slot, never at its next-state logic.
  assign HazardStall = IdValid && ctrl_p1.valid && ctrl_p1.mem_read &&
                       (ctrl_p1.rd != ZR) &&
                       ((ctrl_p1.rd == IdRn) || (ctrl_p1.rd == IdRm)) &&
                       !Flush;

  // ---- stage p1: ID/EX register ----
  // Flush beats Stall; a stalled hazard keeps the load in EX until Stall drops.
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      ctrl_p1 <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
    end else if (Stall) begin
      ctrl_p1 <= ctrl_p1;
      a_p1    <= a_p1;
      b_p1    <= b_p1;
    end else if (HazardStall) begin
      ctrl_p1 <= '0;
      a_p1    <= '0;
      b_p1    <= '0;
    end else begin
      ctrl_p1 <= ctrl_p0;
      a_p1    <= op_a_p0;
      b_p1    <= op_b_p0;
    end
  end

  assign vld_p1     = ctrl_p1.valid;
  assign ExValid    = vld_p1;
  assign ExRegWrite = ctrl_p1.reg_write;
  assign ExMemRead  = ctrl_p1.mem_read;
  assign ExRd       = ctrl_p1.rd;
  assign ExA        = a_p1;
  assign ExB        = b_p1;

endmodule
